// File: rtl/m65c02_mem_responder.sv
// Bus responder for the m65c02 core: serves each transfer from an internal RAM
// window (with programmable wait states) or an external req/ack port with timeout.
module m65c02_mem_responder #(
    parameter int unsigned pRAM_AW   = 12,
    parameter logic [15:0] pRAM_Base = 16'h0000,
    parameter int unsigned pWS_RAM   = 0,
    parameter int unsigned pTimeout  = 15,
    parameter logic [7:0]  pErrData  = 8'hFF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  IO_Op,
    input  logic [15:0] AO,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        Rdy,
    output logic        Valid,
    output logic        Ext_Req,
    output logic        Ext_WE,
    output logic [15:0] Ext_A,
    output logic [7:0]  Ext_DO,
    input  logic [7:0]  Ext_DI,
    input  logic        Ext_Ack,
    output logic        Bus_Err
);

    localparam int unsigned RamDepth = 2 ** pRAM_AW;
    localparam logic [3:0]  WsInit   = 4'(pWS_RAM);
    localparam logic [7:0]  TmoInit  = 8'(pTimeout);

    typedef enum logic [1:0] {StIdle, StWait, StExt} state_e;

    state_e              state_q, state_d;
    logic [7:0]          mem [RamDepth];
    logic                accept, ram_hit, is_rd_op, ram_we;
    logic                ws_last, tmo_last, ext_done;
    logic [pRAM_AW-1:0]  ram_off;

    logic        rdy_d, valid_d, bus_err_d, ext_req_d, ext_we_d, rd_d, rd_q;
    logic [7:0]  di_d, ext_do_d, tmo_d, tmo_q;
    logic [15:0] ext_a_d;
    logic [3:0]  ws_d, ws_q;

    assign accept   = (state_q == StIdle) && (IO_Op != 2'b00);
    assign ram_hit  = (AO[15:pRAM_AW] == pRAM_Base[15:pRAM_AW]);
    assign ram_off  = AO[pRAM_AW-1:0];
    assign is_rd_op = IO_Op[1];  // 2 = read, 3 = fetch
    assign ram_we   = accept && ram_hit && (IO_Op == 2'b01);
    assign ws_last  = (ws_q == 4'd1);
    assign tmo_last = (tmo_q == 8'd1);
    // Ack has priority over an expiry on the same edge.
    assign ext_done = Ext_Ack || tmo_last;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!ram_hit) begin
                        state_d = StExt;
                    end else if (WsInit != 4'd0) begin
                        state_d = StWait;
                    end
                end
            end
            StWait:  if (ws_last) state_d = StIdle;
            StExt:   if (ext_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdy_d     = (state_d == StIdle);
        valid_d   = 1'b0;
        bus_err_d = 1'b0;
        di_d      = DI;
        rd_d      = rd_q;
        ws_d      = ws_q;
        tmo_d     = tmo_q;
        ext_req_d = Ext_Req;
        ext_we_d  = Ext_WE;
        ext_a_d   = Ext_A;
        ext_do_d  = Ext_DO;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rd_d = is_rd_op;
                    if (ram_hit) begin
                        ws_d = WsInit;
                        if (is_rd_op) begin
                            di_d = mem[ram_off];
                        end
                        valid_d = is_rd_op && (WsInit == 4'd0);
                    end else begin
                        tmo_d     = TmoInit;
                        ext_req_d = 1'b1;
                        ext_we_d  = (IO_Op == 2'b01);
                        ext_a_d   = AO;
                        ext_do_d  = DO;
                    end
                end
            end
            StWait: begin
                ws_d    = ws_q - 4'd1;
                valid_d = ws_last && rd_q;
            end
            StExt: begin
                if (Ext_Ack) begin
                    ext_req_d = 1'b0;
                    valid_d   = rd_q;
                    if (rd_q) di_d = Ext_DI;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                    if (tmo_last) begin
                        ext_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        valid_d   = rd_q;
                        if (rd_q) di_d = pErrData;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Rdy     <= 1'b1;
            Valid   <= 1'b0;
            Bus_Err <= 1'b0;
            DI      <= 8'h00;
            rd_q    <= 1'b0;
            ws_q    <= 4'd0;
            tmo_q   <= 8'd0;
            Ext_Req <= 1'b0;
            Ext_WE  <= 1'b0;
            Ext_A   <= 16'h0000;
            Ext_DO  <= 8'h00;
        end else begin
            Rdy     <= rdy_d;
            Valid   <= valid_d;
            Bus_Err <= bus_err_d;
            DI      <= di_d;
            rd_q    <= rd_d;
            ws_q    <= ws_d;
            tmo_q   <= tmo_d;
            Ext_Req <= ext_req_d;
            Ext_WE  <= ext_we_d;
            Ext_A   <= ext_a_d;
            Ext_DO  <= ext_do_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            mem[ram_off] <= DO;
        end
    end

endmodule

// File: tb/tb_m65c02_mem_responder.sv
// Directed bench for m65c02_mem_responder: zero-wait RAM, 3-wait RAM, external
// ack, timeouts on write and read, and asynchronous reset mid-access.
module tb_m65c02_mem_responder;

    logic        Clk;
    logic        Rst;
    logic [1:0]  IO_Op, IO_Op3;
    logic [15:0] AO;
    logic [7:0]  DO;
    logic [7:0]  Ext_DI;
    logic        Ext_Ack;

    logic [7:0]  DI, DI3;
    logic        Rdy, Rdy3, Valid, Valid3;
    logic        Ext_Req, Ext_Req3, Ext_WE, Ext_WE3, Bus_Err, Bus_Err3;
    logic [15:0] Ext_A, Ext_A3;
    logic [7:0]  Ext_DO, Ext_DO3;

    int total = 0;
    int bad   = 0;

    m65c02_mem_responder #(.pWS_RAM(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .IO_Op(IO_Op), .AO(AO), .DO(DO), .DI(DI),
        .Rdy(Rdy), .Valid(Valid), .Ext_Req(Ext_Req), .Ext_WE(Ext_WE),
        .Ext_A(Ext_A), .Ext_DO(Ext_DO), .Ext_DI(Ext_DI), .Ext_Ack(Ext_Ack),
        .Bus_Err(Bus_Err)
    );

    m65c02_mem_responder #(.pWS_RAM(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst), .IO_Op(IO_Op3), .AO(AO), .DO(DO), .DI(DI3),
        .Rdy(Rdy3), .Valid(Valid3), .Ext_Req(Ext_Req3), .Ext_WE(Ext_WE3),
        .Ext_A(Ext_A3), .Ext_DO(Ext_DO3), .Ext_DI(Ext_DI), .Ext_Ack(Ext_Ack),
        .Bus_Err(Bus_Err3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Sample 1 time unit after the rising edge, then drive the next inputs.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; IO_Op = 2'd0; IO_Op3 = 2'd0; AO = 16'h0; DO = 8'h0;
        Ext_DI = 8'h0; Ext_Ack = 1'b0;
        tick(); tick();
        total++;
        if (Rdy !== 1'b1 || Valid !== 1'b0 || DI !== 8'h00 || Bus_Err !== 1'b0) begin
            bad++;
            $display("FAIL reset_core rdy=%b valid=%b di=%h berr=%b want 1 0 00 0",
                     Rdy, Valid, DI, Bus_Err);
        end
        total++;
        if (Ext_Req !== 1'b0 || Ext_WE !== 1'b0 || Ext_A !== 16'h0 || Ext_DO !== 8'h0) begin
            bad++;
            $display("FAIL reset_ext req=%b we=%b a=%h do=%h want 0 0 0000 00",
                     Ext_Req, Ext_WE, Ext_A, Ext_DO);
        end
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_ram_zero_wait();
        IO_Op = 2'd1; AO = 16'h0123; DO = 8'h5A;
        tick();
        total++;
        if (Rdy !== 1'b1 || Valid !== 1'b0) begin
            bad++;
            $display("FAIL ws0_write rdy=%b valid=%b want 1 0", Rdy, Valid);
        end
        IO_Op = 2'd2;
        tick();
        total++;
        if (Rdy !== 1'b1 || Valid !== 1'b1 || DI !== 8'h5A) begin
            bad++;
            $display("FAIL ws0_read rdy=%b valid=%b di=%h want 1 1 5a", Rdy, Valid, DI);
        end
        IO_Op = 2'd0;
        tick();
        total++;
        if (Valid !== 1'b0 || DI !== 8'h5A || Rdy !== 1'b1) begin
            bad++;
            $display("FAIL ws0_idle valid=%b di=%h rdy=%b want 0 5a 1", Valid, DI, Rdy);
        end
    endtask

    task automatic test_ram_wait_states();
        int n;
        IO_Op3 = 2'd1; AO = 16'h0010; DO = 8'hA9;
        tick();
        IO_Op3 = 2'd0;
        n = 0;
        while (Rdy3 === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n != 3 || Valid3 !== 1'b0) begin
            bad++;
            $display("FAIL ws3_write lowcycles=%0d valid=%b want 3 0", n, Valid3);
        end
        IO_Op3 = 2'd3; AO = 16'h0010;
        tick();
        IO_Op3 = 2'd0;
        n = 0;
        while (Rdy3 === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n != 3 || Rdy3 !== 1'b1 || Valid3 !== 1'b1 || DI3 !== 8'hA9) begin
            bad++;
            $display("FAIL ws3_fetch lowcycles=%0d rdy=%b valid=%b di=%h want 3 1 1 a9",
                     n, Rdy3, Valid3, DI3);
        end
        tick();
        total++;
        if (Valid3 !== 1'b0) begin
            bad++;
            $display("FAIL ws3_valid_pulse valid=%b want 0", Valid3);
        end
    endtask

    task automatic test_ack_idle();
        Ext_Ack = 1'b1; Ext_DI = 8'h55;
        tick();
        Ext_Ack = 1'b0;
        tick();
        total++;
        if (Valid !== 1'b0 || DI !== 8'h5A || Rdy !== 1'b1) begin
            bad++;
            $display("FAIL ack_idle valid=%b di=%h rdy=%b want 0 5a 1", Valid, DI, Rdy);
        end
    endtask

    task automatic test_ext_read_ack();
        int errs;
        IO_Op = 2'd2; AO = 16'hF000;
        tick();
        IO_Op = 2'd0; AO = 16'h1234;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            if (Ext_Req !== 1'b1 || Ext_A !== 16'hF000 || Ext_WE !== 1'b0 || Rdy !== 1'b0)
                errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL ext_hold bad_cycles=%0d want 0 (req=%b a=%h we=%b rdy=%b)",
                     errs, Ext_Req, Ext_A, Ext_WE, Rdy);
        end
        Ext_Ack = 1'b1; Ext_DI = 8'h3C;
        tick();
        Ext_Ack = 1'b0; Ext_DI = 8'h00;
        total++;
        if (Ext_Req !== 1'b0 || Rdy !== 1'b1 || Valid !== 1'b1 || DI !== 8'h3C
            || Bus_Err !== 1'b0) begin
            bad++;
            $display("FAIL ext_ack req=%b rdy=%b valid=%b di=%h berr=%b want 0 1 1 3c 0",
                     Ext_Req, Rdy, Valid, DI, Bus_Err);
        end
    endtask

    task automatic test_ext_write_timeout();
        int n;
        int errs;
        IO_Op = 2'd1; AO = 16'hE000; DO = 8'h77;
        tick();
        IO_Op = 2'd0;
        n = 0;
        errs = 0;
        while (Ext_Req === 1'b1 && n < 40) begin
            if (Ext_DO !== 8'h77 || Ext_WE !== 1'b1 || Valid !== 1'b0 || Bus_Err !== 1'b0)
                errs++;
            n++;
            tick();
        end
        total++;
        if (n != 15 || errs != 0) begin
            bad++;
            $display("FAIL wr_timeout_len req_cycles=%0d bad_cycles=%0d want 15 0", n, errs);
        end
        total++;
        if (Bus_Err !== 1'b1 || Valid !== 1'b0 || Rdy !== 1'b1) begin
            bad++;
            $display("FAIL wr_timeout_end berr=%b valid=%b rdy=%b want 1 0 1",
                     Bus_Err, Valid, Rdy);
        end
        tick();
        total++;
        if (Bus_Err !== 1'b0) begin
            bad++;
            $display("FAIL wr_berr_pulse berr=%b want 0", Bus_Err);
        end
    endtask

    task automatic test_ext_read_timeout();
        int n;
        IO_Op = 2'd2; AO = 16'hFFFC;
        tick();
        IO_Op = 2'd0;
        n = 0;
        while (Ext_Req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++;
        if (n != 15 || DI !== 8'hFF || Valid !== 1'b1 || Bus_Err !== 1'b1) begin
            bad++;
            $display("FAIL rd_timeout cycles=%0d di=%h valid=%b berr=%b want 15 ff 1 1",
                     n, DI, Valid, Bus_Err);
        end
    endtask

    task automatic test_reset_mid_access();
        int vcount;
        IO_Op = 2'd2; AO = 16'hF000;
        tick();
        IO_Op = 2'd0;
        tick(); tick();
        #2;
        Rst = 1'b0;
        #1;
        total++;
        if (Ext_Req !== 1'b0 || Rdy !== 1'b1) begin
            bad++;
            $display("FAIL async_reset req=%b rdy=%b want 0 1", Ext_Req, Rdy);
        end
        tick();
        #2;
        Rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Valid !== 1'b0 || Ext_Req !== 1'b0) vcount++;
        end
        total++;
        if (vcount != 0) begin
            bad++;
            $display("FAIL post_reset_quiet bad_cycles=%0d want 0", vcount);
        end
        IO_Op = 2'd2; AO = 16'h0123;
        tick();
        IO_Op = 2'd0;
        total++;
        if (Valid !== 1'b1 || DI !== 8'h5A || Rdy !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_read valid=%b di=%h rdy=%b want 1 5a 1", Valid, DI, Rdy);
        end
    endtask

    initial begin
        test_reset();
        test_ram_zero_wait();
        test_ram_wait_states();
        test_ack_idle();
        test_ext_read_ack();
        test_ext_write_timeout();
        test_ext_read_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
